// File: rtl/button_event_decoder.sv
// button_event_decoder
//   Converts a debounced button level into single-cycle event pulses.
//   The events are press, release, short click, double click and long hold.
//   One shared interval counter times the long-hold, double-click and repeat intervals.
//   Optional feature macro: BTN_REPEAT_EN. When it is defined, o_repeat emits a
//   pulse train while the button is long-held. Without it, o_repeat is tied to 0.
module button_event_decoder #(
  parameter int CNT_W        = 24,
  parameter int LONG_TICKS   = 6_000_000,
  parameter int DCLICK_TICKS = 3_000_000,
  parameter int REPEAT_TICKS = 1_200_000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_press,
  output logic o_release,
  output logic o_short,
  output logic o_double,
  output logic o_long,
  output logic o_repeat
);

  // Every interval must last at least two cycles, so that a state can always be
  // left before its timeout compare fires.
  if (LONG_TICKS < 2 || DCLICK_TICKS < 2 || REPEAT_TICKS < 2) begin : g_bad_param
    $error("button_event_decoder: LONG/DCLICK/REPEAT_TICKS must all be >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HELD   = 3'd1,
    S_LONG   = 3'd2,
    S_WAIT   = 3'd3,
    S_SECOND = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_TICKS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             prev_q;
  logic             rise, fall;
  logic             press_q, release_q;
  logic             short_q, short_d;
  logic             double_q, double_d;
  logic             long_q, long_d;

`ifdef BTN_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
  logic repeat_q, repeat_d;
  assign o_repeat = repeat_q;
`else
  assign o_repeat = 1'b0;
`endif

  assign rise = i_btn & ~prev_q;
  assign fall = ~i_btn & prev_q;

  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_short   = short_q;
  assign o_double  = double_q;
  assign o_long    = long_q;

  // Next-state and gesture classification. A fall beats the long timeout, and a
  // rise beats the double-click timeout.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
`ifdef BTN_REPEAT_EN
    repeat_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d = S_HELD;
          cnt_d   = '0;
        end
      end
      S_HELD: begin
        cnt_d = cnt_q + 1'b1;
        if (fall) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = S_LONG;
          cnt_d   = '0;
        end
      end
      S_LONG: begin
`ifdef BTN_REPEAT_EN
        cnt_d = cnt_q + 1'b1;
        if (fall) begin
          state_d = S_IDLE;
        end else if (cnt_q == REPEAT_LAST) begin
          repeat_d = 1'b1;
          cnt_d    = '0;
        end
`else
        if (fall) begin
          state_d = S_IDLE;
        end
`endif
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (rise) begin
          double_d = 1'b1;
          state_d  = S_SECOND;
        end else if (cnt_q == DCLICK_LAST) begin
          short_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_SECOND: begin
        if (fall) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter, edge history and registered event outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      prev_q    <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      double_q  <= 1'b0;
      long_q    <= 1'b0;
`ifdef BTN_REPEAT_EN
      repeat_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prev_q    <= i_btn;
      press_q   <= rise;
      release_q <= fall;
      short_q   <= short_d;
      double_q  <= double_d;
      long_q    <= long_d;
`ifdef BTN_REPEAT_EN
      repeat_q  <= repeat_d;
`endif
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Testbench for button_event_decoder (LONG=8, DCLICK=4, REPEAT=3).
module tb_button_event_decoder;

  localparam int LONG_T   = 8;
  localparam int DCLICK_T = 4;
  localparam int REPEAT_T = 3;
`ifdef BTN_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  // Output vector order: {press, release, short, double, long, repeat}
  localparam logic [5:0] P  = 6'b100000;
  localparam logic [5:0] R  = 6'b010000;
  localparam logic [5:0] S  = 6'b001000;
  localparam logic [5:0] D  = 6'b000100;
  localparam logic [5:0] L  = 6'b000010;
  localparam logic [5:0] RP = 6'b000001;
  localparam logic [5:0] Z  = 6'b000000;

  logic clk, rst, btn;
  logic o_press, o_release, o_short, o_double, o_long, o_repeat;
  logic [5:0] dut_v;

  int checks = 0;
  int errors = 0;

  button_event_decoder #(
    .CNT_W(8), .LONG_TICKS(LONG_T), .DCLICK_TICKS(DCLICK_T), .REPEAT_TICKS(REPEAT_T)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_btn(btn),
    .o_press(o_press), .o_release(o_release), .o_short(o_short),
    .o_double(o_double), .o_long(o_long), .o_repeat(o_repeat)
  );

  assign dut_v = {o_press, o_release, o_short, o_double, o_long, o_repeat};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: gesture phases with entry timestamps, evaluated once per clock edge.
  int n, t0;
  bit m_prev, m_first, m_long, m_wait, m_second;
  logic [5:0] m_exp;

  task automatic model_reset();
    n = 0; t0 = 0;
    m_prev = 0; m_first = 0; m_long = 0; m_wait = 0; m_second = 0;
    m_exp = Z;
  endtask

  task automatic model_edge(input bit b);
    bit r, f;
    n++;
    r = b && !m_prev;
    f = !b && m_prev;
    m_prev = b;
    m_exp = Z;
    if (r) m_exp |= P;
    if (f) m_exp |= R;
    if (m_first) begin
      if (f) begin m_first = 0; m_wait = 1; t0 = n; end
      else if (n - t0 == LONG_T) begin m_exp |= L; m_first = 0; m_long = 1; t0 = n; end
    end else if (m_long) begin
      if (f) m_long = 0;
      else if (REP && (n - t0 == REPEAT_T)) begin m_exp |= RP; t0 = n; end
    end else if (m_wait) begin
      if (r) begin m_exp |= D; m_wait = 0; m_second = 1; end
      else if (n - t0 == DCLICK_T) begin m_exp |= S; m_wait = 0; end
    end else if (m_second) begin
      if (f) m_second = 0;
    end else if (r) begin
      m_first = 1; t0 = n;
    end
  endtask

  task automatic check(input string name, input logic [5:0] want);
    checks++;
    if (dut_v !== want) begin
      errors++;
      $display("FAIL %s t=%0t: outputs %b, expected %b", name, $time, dut_v, want);
    end
  endtask

  // One cycle: drive at negedge, clock edge, sample at the following negedge.
  task automatic step(input bit b, input logic [5:0] exp, input bit use_model, input string name);
    btn = b;
    @(posedge clk);
    model_edge(b);
    @(negedge clk);
    check(name, use_model ? m_exp : exp);
  endtask

  task automatic reset_pulse(input bit b_during);
    btn = b_during;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset_outputs", Z);
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct packed {
    logic       btn;
    logic [5:0] exp;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic b, input logic [5:0] e);
    vec_t v;
    v.btn = b;
    v.exp = e;
    tbl.push_back(v);
  endtask

  initial begin
    logic [5:0] e;
    bit lvl;
    rst = 1'b0;
    btn = 1'b0;
    model_reset();
    @(negedge clk);

    // 1: reset, idle quiet
    reset_pulse(1'b0);
    for (int k = 0; k < 10; k++) step(1'b0, Z, 1'b0, "idle_quiet");

    // 2: single click; 3: double click; 5: second press on the timeout edge
    add(1, P); add(1, Z); add(1, Z); add(0, R); add(0, Z); add(0, Z); add(0, Z);
    add(0, S); add(0, Z); add(0, Z);
    add(1, P); add(1, Z); add(0, R); add(0, Z); add(1, P | D); add(1, Z); add(0, R);
    for (int k = 0; k < 5; k++) add(0, Z);
    add(1, P); add(0, R); add(0, Z); add(0, Z); add(0, Z); add(1, P | D); add(0, R);
    for (int k = 0; k < 5; k++) add(0, Z);
    foreach (tbl[i]) step(tbl[i].btn, tbl[i].exp, 1'b0, $sformatf("table_%0d", i));

    // 4: long hold of 20 cycles
    for (int k = 1; k <= 28; k++) begin
      e = Z;
      if (k == 1) e = P;
      if (k == 1 + LONG_T) e = L;
      if (REP && k > 1 + LONG_T && k <= 20 && ((k - 1 - LONG_T) % REPEAT_T) == 0) e = RP;
      if (k == 21) e = R;
      step(k <= 20, e, 1'b0, $sformatf("long_%0d", k));
    end

    // 6: reset during the double-click wait clears outputs at once and drops the click
    step(1'b1, P, 1'b0, "rst6_press");
    step(1'b0, R, 1'b0, "rst6_release");
    #1 rst = 1'b1;
    #1 check("rst6_async_clear", Z);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 10; k++) step(1'b0, Z, 1'b0, "rst6_no_short");

    // Level already high when reset is released counts as a press
    reset_pulse(1'b1);
    for (int k = 1; k <= 14; k++) begin
      e = Z;
      if (k == 1) e = P;
      if (k == 1 + LONG_T) e = L;
      if (k == 10) e = R;
      step(k < 10, e, 1'b0, $sformatf("high_at_reset_%0d", k));
    end

    // Randomised runs of held/released levels checked against the model
    lvl = 1'b0;
    for (int seg = 0; seg < 400; seg++) begin
      lvl = ~lvl;
      for (int k = 0, len = $urandom_range(1, 14); k < len; k++)
        step(lvl, Z, 1'b1, "random");
      if ($urandom_range(0, 39) == 0) begin
        #2 rst = 1'b1;
        #1 check("random_async_clear", Z);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
      end
    end
    for (int k = 0; k < 20; k++) step(1'b0, Z, 1'b1, "random_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
